dram_req_arbiter: RTL and testbench

//  Shares the single DRAM controller request port between NUM_REQ block requesters
//  (the per-queue DRAM store and remove engines of the DRAM output queues).

---
 rtl/dram_req_arbiter_if.sv | 52 +++++
 rtl/dram_req_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dram_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_req_arbiter_if
//  Bundles the requester-side and DRAM-controller-side handshake signals of
//  the DRAM request arbiter.
//
//  Parameters
//   NUM_REQ          number of block requesters
//   DRAM_ADDR_WIDTH  DRAM block pointer width
//   ID_WIDTH         grant id width
//
//  Signals
//   req, req_is_wr, req_ptr    requester levels, direction and flattened pointers
//   req_ack, req_done          one-hot pulses routed back to the owner
//   dram_req, dram_is_wr,      request to the DRAM controller
//   dram_ptr
//   dram_ack, dram_done        controller accept / block-finished pulses
//   grant_vld, grant_id        current ownership, used to mux the data path
//
//  Modports
//   master  the arbiter itself
//   slave   the environment (requesters plus DRAM controller)
// -----------------------------------------------------------------------------
interface dram_req_arbiter_if #(
    parameter int NUM_REQ         = 8,
    parameter int DRAM_ADDR_WIDTH = 22,
    parameter int ID_WIDTH        = 3
);
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0]                 req_is_wr;
    logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0] req_ptr;
    logic [NUM_REQ-1:0]                 req_ack;
    logic [NUM_REQ-1:0]                 req_done;
    logic                               dram_req;
    logic                               dram_is_wr;
    logic [DRAM_ADDR_WIDTH-1:0]         dram_ptr;
    logic                               dram_ack;
    logic                               dram_done;
    logic                               grant_vld;
    logic [ID_WIDTH-1:0]                grant_id;

    modport master (
        input  req, req_is_wr, req_ptr, dram_ack, dram_done,
        output req_ack, req_done, dram_req, dram_is_wr, dram_ptr,
               grant_vld, grant_id
    );

    modport slave (
        output req, req_is_wr, req_ptr, dram_ack, dram_done,
        input  req_ack, req_done, dram_req, dram_is_wr, dram_ptr,
               grant_vld, grant_id
    );
endinterface

// File: rtl/dram_req_arbiter.sv
// -----------------------------------------------------------------------------
// dram_req_arbiter
//  Shares the single DRAM controller request port between NUM_REQ block
//  requesters using round-robin arbitration. A grant is held from issue until
//  the controller reports the block transfer done; ack and done pulses are
//  routed back only to the owning requester. The data path is muxed outside
//  this block using grant_id.
//
//  Ports
//   clk         clock
//   reset       synchronous, active-high
//   arb_enable  0 blocks new grants (a running transfer still completes)
//   bus         dram_req_arbiter_if.master (requester and controller signals)
//
//  Configuration macro
//   DRAM_ARB_WR_PRIO_EN  when defined, write requesters are arbitrated ahead
//                        of readers (round-robin inside each class, shared
//                        pointer). Undefined: plain round-robin.
//
//  The interface instance must use the same parameter values as this module.
// -----------------------------------------------------------------------------
module dram_req_arbiter #(
    parameter int NUM_REQ         = 8,
    parameter int DRAM_ADDR_WIDTH = 22,
    parameter int ID_WIDTH        = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arb_enable,
    dram_req_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_BUSY  = 3'b100
    } state_t;

    state_t                     state_q;
    logic [ID_WIDTH-1:0]        rr_q;
    logic [ID_WIDTH-1:0]        grant_id_q;
    logic                       dram_req_q;
    logic                       dram_is_wr_q;
    logic                       grant_vld_q;
    logic [DRAM_ADDR_WIDTH-1:0] dram_ptr_q;

    logic [NUM_REQ-1:0]         arb_mask_s;
    logic [ID_WIDTH:0]          pick_s;
    logic                       win_vld_s;
    logic [ID_WIDTH-1:0]        win_id_s;
    logic                       win_is_wr_s;
    logic [DRAM_ADDR_WIDTH-1:0] win_ptr_s;
    logic                       ack_s;
    logic                       done_s;
    logic                       req_own_s;
    logic [ID_WIDTH-1:0]        rr_d;
    logic [NUM_REQ-1:0]         req_ack_s;
    logic [NUM_REQ-1:0]         req_done_s;
`ifdef DRAM_ARB_WR_PRIO_EN
    logic [NUM_REQ-1:0]         wr_mask_s;
`endif

    // First set bit of mask scanning upward from start, wrapping at NUM_REQ.
    // Returns {found, index}.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [NUM_REQ-1:0]  mask,
        input logic [ID_WIDTH-1:0] start
    );
        logic                found;
        logic                hit;
        logic [ID_WIDTH-1:0] id;
        int                  pos;
        found = 1'b0;
        id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos   = int'(start) + k;
            pos   = (pos >= NUM_REQ) ? (pos - NUM_REQ) : pos;
            hit   = !found && mask[pos];
            id    = hit ? ID_WIDTH'(pos) : id;
            found = found | hit;
        end
        return {found, id};
    endfunction

    // One-hot vector with only bit id set.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_WIDTH-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Arbitration candidate set and round-robin winner selection.
    always_comb begin
`ifdef DRAM_ARB_WR_PRIO_EN
        // Writers go first so the store-side input FIFOs are drained before
        // they can overflow; readers only win when no writer is asking.
        wr_mask_s = bus.req & bus.req_is_wr;
        if (|wr_mask_s) begin
            arb_mask_s = wr_mask_s;
        end else begin
            arb_mask_s = bus.req;
        end
`else
        arb_mask_s = bus.req;
`endif
        pick_s      = rr_pick(arb_mask_s, rr_q);
        win_vld_s   = pick_s[ID_WIDTH] & arb_enable;
        win_id_s    = pick_s[ID_WIDTH-1:0];
        win_is_wr_s = bus.req_is_wr[win_id_s];
        win_ptr_s   = bus.req_ptr[int'(win_id_s)*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
    end

    // Handshake qualification and ack/done routing to the current owner.
    always_comb begin
        ack_s     = (state_q == ST_ISSUE) && bus.dram_ack;
        // done is only meaningful in BUSY, or in ISSUE together with its ack.
        done_s    = bus.dram_done && ((state_q == ST_BUSY) || ack_s);
        req_own_s = bus.req[grant_id_q];
        if (int'(grant_id_q) == NUM_REQ - 1) begin
            rr_d = '0;
        end else begin
            rr_d = grant_id_q + 1'b1;
        end
        if (ack_s) begin
            req_ack_s = onehot(grant_id_q);
        end else begin
            req_ack_s = '0;
        end
        if (done_s) begin
            req_done_s = onehot(grant_id_q);
        end else begin
            req_done_s = '0;
        end
    end

    // Grant state machine with registered controller-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            grant_id_q   <= '0;
            dram_req_q   <= 1'b0;
            dram_is_wr_q <= 1'b0;
            dram_ptr_q   <= '0;
            grant_vld_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld_s) begin
                        grant_id_q   <= win_id_s;
                        dram_is_wr_q <= win_is_wr_s;
                        dram_ptr_q   <= win_ptr_s;
                        dram_req_q   <= 1'b1;
                        grant_vld_q  <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // ack is checked first: a req drop in the ack cycle is too late to abort.
                    if (ack_s) begin
                        dram_req_q <= 1'b0;
                        if (done_s) begin
                            rr_q        <= rr_d;
                            grant_vld_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end else if (!req_own_s) begin
                        // Requester withdrew before acceptance: abort, rr untouched.
                        dram_req_q  <= 1'b0;
                        grant_vld_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done_s) begin
                        rr_q        <= rr_d;
                        grant_vld_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    dram_req_q  <= 1'b0;
                    grant_vld_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dram_req   = dram_req_q;
    assign bus.dram_is_wr = dram_is_wr_q;
    assign bus.dram_ptr   = dram_ptr_q;
    assign bus.grant_vld  = grant_vld_q;
    assign bus.grant_id   = grant_id_q;
    // ack/done are forwarded in the same cycle they arrive from the controller.
    assign bus.req_ack    = req_ack_s;
    assign bus.req_done   = req_done_s;

endmodule

// File: tb/tb_dram_req_arbiter.sv
module tb_dram_req_arbiter;

    localparam int N  = 8;
    localparam int W  = 22;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset;
    logic arb_enable;

    always #5 clk = ~clk;

    dram_req_arbiter_if #(.NUM_REQ(N), .DRAM_ADDR_WIDTH(W), .ID_WIDTH(IW)) bus ();

    dram_req_arbiter #(.NUM_REQ(N), .DRAM_ADDR_WIDTH(W), .ID_WIDTH(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .arb_enable (arb_enable),
        .bus        (bus)
    );

    int          vectors = 0;
    int          fails   = 0;
    logic [31:0] sb[$];

    function automatic logic [W-1:0] ptr_of(input int i);
        return W'(128 + 64 * i);
    endfunction

    task automatic sb_push(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        vectors++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: observed %0h, scoreboard has no expected entry", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // Wait (bounded) until dram_req is seen high, sampling mid-cycle.
    task automatic wait_req(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            #1;
            if (bus.dram_req === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            fails++;
            $error("FAIL %s: dram_req observed 0 after %0d cycles, expected 1", tag, limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        arb_enable     = 1'b1;
        bus.req        = '0;
        bus.req_is_wr  = '0;
        bus.dram_ack   = 1'b0;
        bus.dram_done  = 1'b0;
        for (int i = 0; i < N; i++) bus.req_ptr[i*W +: W] = ptr_of(i);

        // Reset state
        repeat (2) tick();
        settle();
        sb_push(32'd0); chk("rst_dram_req",   32'(bus.dram_req));
        sb_push(32'd0); chk("rst_grant_vld",  32'(bus.grant_vld));
        sb_push(32'd0); chk("rst_grant_id",   32'(bus.grant_id));
        sb_push(32'd0); chk("rst_dram_ptr",   32'(bus.dram_ptr));
        sb_push(32'd0); chk("rst_dram_is_wr", 32'(bus.dram_is_wr));
        sb_push(32'd0); chk("rst_req_ack",    32'(bus.req_ack));
        sb_push(32'd0); chk("rst_req_done",   32'(bus.req_done));

        // Test 1: single write request from requester 2
        reset         = 1'b0;
        bus.req       = 8'h04;
        bus.req_is_wr = 8'h04;
        settle();
        sb_push(32'd0); chk("t1_no_req_yet", 32'(bus.dram_req));
        tick(); settle();
        sb_push(32'd1);      chk("t1_dram_req",  32'(bus.dram_req));
        sb_push(32'h100);    chk("t1_dram_ptr",  32'(bus.dram_ptr));
        sb_push(32'd1);      chk("t1_is_wr",     32'(bus.dram_is_wr));
        sb_push(32'd2);      chk("t1_grant_id",  32'(bus.grant_id));
        sb_push(32'd1);      chk("t1_grant_vld", 32'(bus.grant_vld));
        tick(); settle();
        sb_push(32'd1);      chk("t1_req_held",  32'(bus.dram_req));
        tick();
        bus.dram_ack = 1'b1;
        settle();
        sb_push(32'h04);     chk("t1_req_ack",   32'(bus.req_ack));
        tick();
        bus.dram_ack = 1'b0;
        bus.req      = 8'h00;
        settle();
        sb_push(32'd0);      chk("t1_ack_once",  32'(bus.req_ack));
        sb_push(32'd0);      chk("t1_busy_req",  32'(bus.dram_req));
        sb_push(32'd1);      chk("t1_busy_vld",  32'(bus.grant_vld));
        bus.dram_ack = 1'b1;
        settle();
        sb_push(32'd0);      chk("t1_ack_in_busy", 32'(bus.req_ack));
        bus.dram_ack = 1'b0;
        repeat (6) tick();
        bus.dram_done = 1'b1;
        settle();
        sb_push(32'h04);     chk("t1_req_done",  32'(bus.req_done));
        tick();
        bus.dram_done = 1'b0;
        bus.req       = 8'h09;
        settle();
        sb_push(32'd0);      chk("t1_done_once", 32'(bus.req_done));
        sb_push(32'd0);      chk("t1_idle_vld",  32'(bus.grant_vld));
        tick(); settle();
        sb_push(32'd3);               chk("t1_rr3_grant", 32'(bus.grant_id));
        sb_push(32'(ptr_of(3)));      chk("t1_rr3_ptr",   32'(bus.dram_ptr));
        sb_push(32'd0);               chk("t1_rr3_is_wr", 32'(bus.dram_is_wr));
        bus.dram_ack  = 1'b1;
        bus.dram_done = 1'b1;
        bus.req       = 8'h00;
        settle();
        sb_push(32'h08);     chk("t1_id3_ack",   32'(bus.req_ack));
        sb_push(32'h08);     chk("t1_id3_done",  32'(bus.req_done));
        tick();
        bus.dram_ack  = 1'b0;
        bus.dram_done = 1'b0;
        settle();
        sb_push(32'd0);      chk("t1_id3_idle",  32'(bus.grant_vld));
        bus.dram_ack  = 1'b1;
        bus.dram_done = 1'b1;
        settle();
        sb_push(32'd0);      chk("idle_ack_ignored",  32'(bus.req_ack));
        sb_push(32'd0);      chk("idle_done_ignored", 32'(bus.req_done));
        tick();
        bus.dram_ack  = 1'b0;
        bus.dram_done = 1'b0;

        // Test 2: all requesting, round-robin order 0..7,0 from rr=0
        reset = 1'b1;
        repeat (2) tick();
        reset         = 1'b0;
        bus.req_is_wr = 8'h00;
        bus.req       = 8'hFF;
        for (int i = 0; i < 9; i++) sb_push(32'(i % N));
        for (int i = 0; i < 9; i++) begin
            wait_req("t2_wait", 4);
            chk("t2_grant", 32'(bus.grant_id));
            bus.dram_ack  = 1'b1;
            bus.dram_done = 1'b1;
            tick();
            bus.dram_ack  = 1'b0;
            bus.dram_done = 1'b0;
        end
        bus.req = 8'h00;

        // Test 3: same-cycle ack and done for id 5 (rr is 1 here)
        tick();
        bus.req = 8'h20;
        wait_req("t3_wait", 4);
        sb_push(32'd5);      chk("t3_grant",  32'(bus.grant_id));
        bus.dram_ack  = 1'b1;
        bus.dram_done = 1'b1;
        settle();
        sb_push(32'h20);     chk("t3_ack",    32'(bus.req_ack));
        sb_push(32'h20);     chk("t3_done",   32'(bus.req_done));
        tick();
        bus.dram_ack  = 1'b0;
        bus.dram_done = 1'b0;
        bus.req       = 8'h60;
        settle();
        sb_push(32'd0);      chk("t3_idle",   32'(bus.grant_vld));
        tick(); settle();
        sb_push(32'd6);      chk("t3_rr6",    32'(bus.grant_id));
        bus.req = 8'h00;
        settle();
        sb_push(32'd0);      chk("t3_abort_noack", 32'(bus.req_ack));
        tick(); settle();
        sb_push(32'd0);      chk("t3_abort_vld",   32'(bus.grant_vld));
        sb_push(32'd0);      chk("t3_abort_req",   32'(bus.dram_req));

        // Test 4: requester 1 drops before ack, requester 3 still high (rr is 6)
        bus.req = 8'h0A;
        wait_req("t4_wait", 4);
        sb_push(32'd1);      chk("t4_grant1", 32'(bus.grant_id));
        bus.req = 8'h08;
        settle();
        sb_push(32'd0);      chk("t4_no_ack", 32'(bus.req_ack));
        tick(); settle();
        sb_push(32'd0);      chk("t4_abort",  32'(bus.grant_vld));
        tick(); settle();
        sb_push(32'd3);      chk("t4_grant3", 32'(bus.grant_id));
        sb_push(32'd1);      chk("t4_req3",   32'(bus.dram_req));
        bus.dram_ack = 1'b1;
        bus.req      = 8'h00;
        settle();
        sb_push(32'h08);     chk("t4_ack_wins", 32'(bus.req_ack));
        tick();
        bus.dram_ack = 1'b0;
        settle();
        sb_push(32'd1);      chk("t4_busy_vld", 32'(bus.grant_vld));
        bus.dram_done = 1'b1;
        settle();
        sb_push(32'h08);     chk("t4_done",   32'(bus.req_done));
        tick();
        bus.dram_done = 1'b0;

        // Test 5: arb_enable=0 during BUSY of id 0
        bus.req = 8'h01;
        wait_req("t5_wait", 4);
        sb_push(32'd0);      chk("t5_grant0", 32'(bus.grant_id));
        bus.dram_ack = 1'b1;
        tick();
        bus.dram_ack = 1'b0;
        arb_enable   = 1'b0;
        tick();
        bus.dram_done = 1'b1;
        settle();
        sb_push(32'h01);     chk("t5_done",   32'(bus.req_done));
        tick();
        bus.dram_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            sb_push(32'd0);  chk("t5_blocked", 32'(bus.dram_req));
            tick();
        end
        arb_enable = 1'b1;
        wait_req("t5_reenable", 2);
        sb_push(32'd0);      chk("t5_regrant", 32'(bus.grant_id));
        bus.dram_ack  = 1'b1;
        bus.dram_done = 1'b1;
        bus.req       = 8'h00;
        tick();
        bus.dram_ack  = 1'b0;
        bus.dram_done = 1'b0;

        // Test 6: writer priority (macro-dependent), rr=0
        reset = 1'b1;
        repeat (2) tick();
        reset         = 1'b0;
        bus.req       = 8'h03;
        bus.req_is_wr = 8'h02;
        wait_req("t6_wait", 4);
`ifdef DRAM_ARB_WR_PRIO_EN
        sb_push(32'd1);
`else
        sb_push(32'd0);
`endif
        chk("t6_grant", 32'(bus.grant_id));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
